// File: rtl/hp_au_seq.sv
// hp_au_seq: command/response front-end for the HP-AU arithmetic unit.
// Multiply (sel = 8) runs on an iterative shift-add engine producing a
// 2*WIDTH product. Every other opcode goes to the combinational hp_au_top.

// hp_au_top: combinational ALU, one result per opcode.
//   0 add    1 sub    2 and    3 or     4 xor    5 not a   6 a<<1   7 a>>1
//   8 zero (multiply is handled by the sequencer)
//   9 nand  10 nor   11 xnor  12 pass a 13 pass b 14 a+1   15 a-1
module hp_au_top #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       sel_i,
    output logic [WIDTH-1:0] y_o
);

    // Opcode decode
    always_comb begin
        y_o = '0;
        case (sel_i)
            4'd0:  y_o = a_i + b_i;
            4'd1:  y_o = a_i - b_i;
            4'd2:  y_o = a_i & b_i;
            4'd3:  y_o = a_i | b_i;
            4'd4:  y_o = a_i ^ b_i;
            4'd5:  y_o = ~a_i;
            4'd6:  y_o = a_i << 1;
            4'd7:  y_o = a_i >> 1;
            4'd9:  y_o = ~(a_i & b_i);
            4'd10: y_o = ~(a_i | b_i);
            4'd11: y_o = ~(a_i ^ b_i);
            4'd12: y_o = a_i;
            4'd13: y_o = b_i;
            4'd14: y_o = a_i + WIDTH'(1);
            4'd15: y_o = a_i - WIDTH'(1);
            default: y_o = '0;
        endcase
    end

endmodule

module hp_au_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   K_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]      SEL_MUL = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [3:0]           sel_q, sel_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        k_q, k_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     alu_y;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;

    // Registered operands feed the ALU so late cmd_* changes cannot leak in.
    hp_au_top #(.WIDTH(WIDTH)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .y_o   (alu_y)
    );

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = res_q;
    assign rsp_ovf    = ovf_q;

    // Shift-add step: add a << k when bit k of b is set.
    always_comb begin
        partial = '0;
        if (b_q[k_q]) partial = {{WIDTH{1'b0}}, a_q} << k_q;
        acc_sum = acc_q + partial;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        k_d     = k_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sel;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = (cmd_sel == SEL_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
            MUL: begin
                acc_d = acc_sum;
                // Stop exactly at k = WIDTH-1 so the counter never wraps.
                if (k_q == K_LAST) begin
                    res_d   = acc_sum[WIDTH-1:0];
                    ovf_d   = |acc_sum[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_hp_au_seq.sv
// Scoreboard bench for hp_au_seq: the driver pushes expected responses from
// an arithmetic reference model, a negedge monitor pops and compares them.
module tb_hp_au_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_sel;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_ovf;
    logic         busy;

    logic         d4_cmd_valid;
    logic         d4_cmd_ready;
    logic [3:0]   d4_cmd_a;
    logic [3:0]   d4_cmd_b;
    logic [3:0]   d4_cmd_sel;
    logic         d4_rsp_valid;
    logic         d4_rsp_ready;
    logic [3:0]   d4_rsp_result;
    logic         d4_rsp_ovf;
    logic         d4_busy;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rand_bp  = 1'b0;
    logic rr_val   = 1'b1;
    logic prev_v   = 1'b0;

    always #5 clk = ~clk;

    hp_au_seq #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    hp_au_seq u_d4 (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (d4_cmd_valid),
        .cmd_ready  (d4_cmd_ready),
        .cmd_a      (d4_cmd_a),
        .cmd_b      (d4_cmd_b),
        .cmd_sel    (d4_cmd_sel),
        .rsp_valid  (d4_rsp_valid),
        .rsp_ready  (d4_rsp_ready),
        .rsp_result (d4_rsp_result),
        .rsp_ovf    (d4_rsp_ovf),
        .busy       (d4_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random or fixed backpressure, applied after the main thread's drives.
    always @(posedge clk) begin
        #2;
        rsp_ready = rand_bp ? 1'($urandom % 2) : rr_val;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic modulo 2^W.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel, input int t);
        exp_t        e;
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned m  = (1 << W) - 1;
        int unsigned r;
        int unsigned p;
        e.ovf = 1'b0;
        e.lat = t + 2;
        case (sel)
            4'd0:  r = ai + bi;
            4'd1:  r = ai + (m + 1) - bi;
            4'd2:  r = ai & bi;
            4'd3:  r = ai | bi;
            4'd4:  r = ai ^ bi;
            4'd5:  r = m - ai;
            4'd6:  r = ai * 2;
            4'd7:  r = ai / 2;
            4'd9:  r = m - (ai & bi);
            4'd10: r = m - (ai | bi);
            4'd11: r = m - (ai ^ bi);
            4'd12: r = ai;
            4'd13: r = bi;
            4'd14: r = ai + 1;
            4'd15: r = ai + m;
            default: begin
                p     = ai * bi;
                r     = p;
                e.ovf = (p > m);
                e.lat = t + W + 1;
            end
        endcase
        e.res = W'(r & m);
        return e;
    endfunction

    // Monitor: compares every valid cycle, latency on the rising cycle, pops on handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got result %0d with no command outstanding (cycle %0d)",
                         rsp_result, cyc);
            end else begin
                if (!prev_v) check("latency", 64'(cyc), 64'(exp_q[0].lat));
                check("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
                check("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0].ovf));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
        prev_v <= !rst && rsp_valid;
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel, output int t);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        t = cyc;
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd_ready stayed %0d, required 1", cmd_ready);
        end else begin
            exp_q.push_back(model(a, b, sel, t));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = W'($urandom);
        cmd_b     = W'($urandom);
        cmd_sel   = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_sel      = '0;
        d4_cmd_valid = 1'b0;
        d4_cmd_a     = '0;
        d4_cmd_b     = '0;
        d4_cmd_sel   = '0;
        d4_rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_ovf", 64'(rsp_ovf), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // 10*10 with exact handshake timing
        issue(8'd10, 8'd10, 4'd8, t);
        while (cyc < t + 9) @(negedge clk);
        check("t9_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("t10_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // Overflow and zero-operand multiplies
        issue(8'd20, 8'd20, 4'd8, t);   drain();
        issue(8'd255, 8'd255, 4'd8, t); drain();
        issue(8'd37, 8'd0, 4'd8, t);    drain();

        // Every opcode with random operands under random backpressure
        rand_bp = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            for (int s = 0; s < 16; s++) begin
                issue(W'($urandom), W'($urandom), 4'(s), t);
                drain();
            end
        end
        rand_bp = 1'b0;
        rr_val  = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: response must hold while commands are offered
        issue(8'd200, 8'd3, 4'd8, t);
        n = 0;
        while (!rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("bp_valid_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = i[0];
            cmd_a     = W'($urandom);
            cmd_b     = W'($urandom);
            cmd_sel   = 4'($urandom);
            @(negedge clk);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rr_val    = 1'b1;
        drain();
        @(negedge clk);
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply (k = 3)
        issue(8'd10, 8'd10, 4'd8, t);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_mul_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 64'(cmd_ready), 64'd1);
        check("abort_no_stale", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(8'd3, 8'd4, 4'd8, t);
        drain();

        // Default WIDTH=4 instance: 4*4 wraps to 0 with overflow
        d4_cmd_valid = 1'b1;
        d4_cmd_a     = 4'd4;
        d4_cmd_b     = 4'd4;
        d4_cmd_sel   = 4'd8;
        n = 0;
        @(negedge clk);
        while (!d4_cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        t = cyc;
        @(posedge clk);
        #1 d4_cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!d4_rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("w4_latency", 64'(cyc), 64'(t + 5));
        check("w4_result", 64'(d4_rsp_result), 64'd0);
        check("w4_ovf", 64'(d4_rsp_ovf), 64'd1);
        check("w4_valid", 64'(d4_rsp_valid), 64'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_au_seq.md
Name: hp_au_seq

Overview:
Sequential command/response front-end for the HP-AU arithmetic unit. It accepts operand/opcode commands over a valid/ready handshake and returns results over a second valid/ready handshake. Multiply (sel = 8) runs on an internal iterative shift-add engine that produces a full 2*WIDTH product and an overflow flag. Every other opcode is forwarded to an internal hp_au_top instance of the same WIDTH, and its result is registered.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active high.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_a  input  WIDTH  operand A.
cmd_b  input  WIDTH  operand B.
cmd_sel  input  4  opcode; 8 = multiply, others = hp_au_top encoding.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  WIDTH  result, low WIDTH bits.
rsp_ovf  output  1  multiply product did not fit in WIDTH bits; 0 for all other opcodes.
busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock, clk. Reset rst is synchronous and active high.
- Reset (rst high at a clk edge):
  - state goes to IDLE.
  - rsp_valid = 0, rsp_result = 0, rsp_ovf = 0, busy = 0.
  - cmd_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- States: IDLE, EXEC, MUL, DONE.
- cmd_ready = (state == IDLE) && !rst. A command is accepted at an edge where cmd_valid && cmd_ready; cmd_a, cmd_b and cmd_sel are captured into registers.
- IDLE -> MUL on accept with sel = 8. IDLE -> EXEC on accept with any other sel.
- EXEC (1 cycle):
  - The registered operands drive hp_au_top.
  - At the next edge its result is captured into rsp_result, rsp_ovf = 0, and state goes to DONE.
- MUL (WIDTH cycles):
  - Accumulator of 2*WIDTH bits is cleared on accept.
  - Each cycle, counter k (0..WIDTH-1) examines bit k of b. If that bit is 1, (a << k) is added to the accumulator.
  - After the edge that processes k = WIDTH-1: rsp_result = acc[WIDTH-1:0], rsp_ovf = |acc[2*WIDTH-1:WIDTH], state goes to DONE.
- DONE:
  - rsp_valid = 1.
  - rsp_result and rsp_ovf are held stable until the handshake.
  - At an edge with rsp_valid && rsp_ready, state goes to IDLE and rsp_valid goes to 0.
- Latency (T = cycle of the cmd handshake):
  - Non-multiply: rsp_valid first high in cycle T+2.
  - Multiply: rsp_valid first high in cycle T+WIDTH+1.
- Single outstanding command. cmd_ready stays 0 from the accept edge until the edge after the response handshake, so there is no back-to-back overlap.
- Backpressure: rsp_ready may stay low indefinitely. Outputs are frozen and no command is accepted during that time.
- cmd_a, cmd_b and cmd_sel are ignored when no handshake occurs. Changes to them after accept do not affect the operation in flight.
- Reset mid-operation (EXEC, MUL or DONE):
  - The operation is aborted and no response is produced.
  - Outputs return to their reset values at that edge.
- Boundary cases:
  - b = 0 gives result 0, ovf 0.
  - Max*max gives the truncated low half, ovf 1.
  - The counter must not wrap; exactly WIDTH MUL cycles are performed.
  - rsp_ready high in the same cycle rsp_valid first rises completes the handshake at that edge.

Test Plan:
1. WIDTH=8, a=10, b=10, sel=8, rsp_ready=1 -> rsp_result=100, rsp_ovf=0, rsp_valid first in T+9, cmd_ready=1 again in T+10.
2. WIDTH=8, a=20, b=20, sel=8 -> rsp_result=144, rsp_ovf=1. Then a=255, b=255 -> rsp_result=1, rsp_ovf=1. Then a=37, b=0 -> rsp_result=0, rsp_ovf=0.
3. WIDTH=8, sel=0..15 except 8, random a/b -> rsp_result equals a standalone hp_au_top output for the same inputs, rsp_ovf=0, rsp_valid in T+2.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid; toggle cmd_valid and operands -> rsp_result/rsp_ovf stable, cmd_ready=0, no extra response; rsp_ready=1 -> single handshake, return to IDLE.
5. Reset at MUL count k=3 (a=10, b=10) -> next cycle rsp_valid=0, busy=0, cmd_ready=1 after rst deasserts; a following a=3, b=4, sel=8 returns 12 with no stale response.
6. WIDTH=4 default, a=4, b=4, sel=8 -> rsp_result=0, rsp_ovf=1, rsp_valid in T+5.
